// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single-port registered-read RAM.
// It serves one access at a time: IDLE accepts a request, ACCESS drives the RAM, and RESP captures read data.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ram_wen_o,
  output logic                ram_ren_o,
  output logic [DATA_W-1:0]   ram_din_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  input  logic [DATA_W-1:0]   ram_dout_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic                rr_ptr_reg;
  logic                win_reg;
  logic                we_reg;
  logic                sel_next;
  logic [ADDR_W-1:0]   addr_port [2];
  logic [DATA_W-1:0]   wdata_port [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign addr_port[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_port[gi] = wdata_i[gi*DATA_W +: DATA_W];
  end

  // A lone requester wins outright; on contention the round-robin pointer decides.
  always_comb begin
    sel_next = rr_ptr_reg;
    if (req_i == 2'b01)
      sel_next = 1'b0;
    else if (req_i == 2'b10)
      sel_next = 1'b1;
  end

  // The RAM address and data outputs also serve as the latched request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 1'b0;
      win_reg    <= 1'b0;
      we_reg     <= 1'b0;
      gnt_o      <= 2'b00;
      rvalid_o   <= 2'b00;
      rdata_o    <= '0;
      ram_wen_o  <= 1'b0;
      ram_ren_o  <= 1'b0;
      ram_din_o  <= '0;
      ram_addr_o <= '0;
    end else begin
      gnt_o    <= 2'b00;
      rvalid_o <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (|req_i) begin
            win_reg    <= sel_next;
            we_reg     <= we_i[sel_next];
            ram_addr_o <= addr_port[sel_next];
            ram_din_o  <= wdata_port[sel_next];
            ram_wen_o  <= we_i[sel_next];
            ram_ren_o  <= ~we_i[sel_next];
            gnt_o      <= sel_next ? 2'b10 : 2'b01;
            state_reg  <= ACCESS;
          end
        end
        ACCESS: begin
          ram_wen_o  <= 1'b0;
          ram_ren_o  <= 1'b0;
          rr_ptr_reg <= ~win_reg;
          state_reg  <= we_reg ? IDLE : RESP;
        end
        RESP: begin
          rdata_o           <= ram_dout_i;
          rvalid_o[win_reg] <= 1'b1;
          state_reg         <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random-traffic bench for ram_arbiter, with a behavioural registered-read RAM attached.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [1:0]      req_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o, ram_din_o, ram_dout_i;
  logic            ram_wen_o, ram_ren_o;
  logic [AW-1:0]   ram_addr_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:4095];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .ram_wen_o(ram_wen_o), .ram_ren_o(ram_ren_o),
    .ram_din_o(ram_din_o), .ram_addr_o(ram_addr_o), .ram_dout_i(ram_dout_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (ram_wen_o) mem[ram_addr_o] <= ram_din_o;
    if (ram_ren_o) ram_dout_i <= mem[ram_addr_o];
  end

  always @(negedge clk_i) begin
    checks++;
    if (ram_wen_o && ram_ren_o) begin
      errors++;
      $display("FAIL strobe_overlap: wen=%b ren=%b, required not both 1", ram_wen_o, ram_ren_o);
    end
    checks++;
    if ($countones(gnt_o) > 1) begin
      errors++;
      $display("FAIL gnt_onehot: gnt=%b, required at most one bit", gnt_o);
    end
    checks++;
    if ($countones(rvalid_o) > 1) begin
      errors++;
      $display("FAIL rvalid_onehot: rvalid=%b, required at most one bit", rvalid_o);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
  endtask

  task automatic write_word(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_i[p] = 1'b1; we_i[p] = 1'b1;
    addr_i[p*AW +: AW] = a; wdata_i[p*DW +: DW] = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt_o[p] !== 1'b1 && n < 10);
    checks++;
    if (gnt_o[p] !== 1'b1) begin
      errors++;
      $display("FAIL write_grant: port %0d gnt=%b, required grant within 10 cycles", p, gnt_o);
    end
    req_i[p] = 1'b0; we_i[p] = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    logic [2*AW+2*DW+5:0] outs;
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    outs = {gnt_o, rvalid_o, rdata_o, ram_wen_o, ram_ren_o, ram_din_o, ram_addr_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h, required 0", outs);
    end
    rst_ni = 1'b1;
    tick();
    // port 0 read, then reset lands during RESP
    req_i = 2'b01; we_i = 2'b00; addr_i[AW-1:0] = 12'h010;
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL midread_grant: gnt=%b, required 01", gnt_o);
    end
    idle_inputs();
    tick();
    #2 rst_ni = 1'b0;
    #1;
    outs = {gnt_o, rvalid_o, rdata_o, ram_wen_o, ram_ren_o, ram_din_o, ram_addr_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midread_reset: outputs=%h, required 0 immediately", outs);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rvalid_o !== 2'b00 || gnt_o !== 2'b00) begin
        errors++;
        $display("FAIL abandoned_access: rvalid=%b gnt=%b, required 00 00", rvalid_o, gnt_o);
      end
    end
    req_i = 2'b11; we_i = 2'b00; addr_i = {12'h020, 12'h021};
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL rr_ptr_reset: gnt=%b, required 01", gnt_o);
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_single;
    req_i = 2'b10; we_i = 2'b10; addr_i[2*AW-1:AW] = 12'h000; wdata_i[2*DW-1:DW] = 4'b0011;
    tick();
    checks++;
    if ({gnt_o, ram_wen_o, ram_ren_o, ram_addr_o, ram_din_o} !== {2'b10, 1'b1, 1'b0, 12'h000, 4'b0011}) begin
      errors++;
      $display("FAIL single_write: gnt=%b wen=%b ren=%b addr=%h din=%b, required 10 1 0 000 0011",
               gnt_o, ram_wen_o, ram_ren_o, ram_addr_o, ram_din_o);
    end
    idle_inputs();
    tick();
    checks++;
    if (ram_wen_o !== 1'b0 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL single_write_end: wen=%b gnt=%b, required 0 00", ram_wen_o, gnt_o);
    end
    req_i = 2'b10; we_i = 2'b00; addr_i[2*AW-1:AW] = 12'h000;
    tick();
    checks++;
    if ({gnt_o, ram_ren_o, ram_wen_o} !== {2'b10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_read: gnt=%b ren=%b wen=%b, required 10 1 0", gnt_o, ram_ren_o, ram_wen_o);
    end
    idle_inputs();
    tick();
    checks++;
    if (rvalid_o !== 2'b00 || ram_ren_o !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: rvalid=%b ren=%b, required 00 0", rvalid_o, ram_ren_o);
    end
    tick();
    checks++;
    if (rvalid_o !== 2'b10 || rdata_o !== 4'b0011) begin
      errors++;
      $display("FAIL single_rdata: rvalid=%b rdata=%b, required 10 0011", rvalid_o, rdata_o);
    end
    tick();
    checks++;
    if (rvalid_o !== 2'b00 || rdata_o !== 4'b0011) begin
      errors++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%b, required 00 0011", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int ng = 0;
    int nv = 0;
    logic [DW-1:0] exp_d;
    write_word(0, 12'h001, 4'hA);
    write_word(1, 12'h002, 4'h5);
    req_i = 2'b11; we_i = 2'b00; addr_i = {12'h002, 12'h001};
    for (int c = 0; c < 30 && nv < 4; c++) begin
      tick();
      if (gnt_o !== 2'b00 && ng < 4) begin
        checks++;
        if (gnt_o !== exp_g[ng]) begin
          errors++;
          $display("FAIL contention_grant%0d: gnt=%b, required %b", ng, gnt_o, exp_g[ng]);
        end
        ng++;
        if (ng == 4) idle_inputs();
      end
      if (rvalid_o !== 2'b00) begin
        exp_d = (exp_g[nv] == 2'b01) ? 4'hA : 4'h5;
        checks++;
        if (rvalid_o !== exp_g[nv] || rdata_o !== exp_d) begin
          errors++;
          $display("FAIL contention_rvalid%0d: rvalid=%b rdata=%h, required %b %h",
                   nv, rvalid_o, rdata_o, exp_g[nv], exp_d);
        end
        nv++;
      end
    end
    idle_inputs();
    checks++;
    if (ng != 4 || nv != 4) begin
      errors++;
      $display("FAIL contention_count: grants=%0d rvalids=%0d, required 4 4", ng, nv);
    end
    repeat (3) tick();
  endtask

  task automatic test_same_addr;
    int ng = 0;
    int got = 0;
    apply_reset();
    req_i = 2'b11; we_i = 2'b01; addr_i = {12'hFFF, 12'hFFF}; wdata_i = {4'b0000, 4'b0101};
    for (int c = 0; c < 12; c++) begin
      tick();
      if (gnt_o !== 2'b00) begin
        checks++;
        if (gnt_o !== ((ng == 0) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL order_grant%0d: gnt=%b, required %b", ng, gnt_o, (ng == 0) ? 2'b01 : 2'b10);
        end
        if (gnt_o[0]) req_i[0] = 1'b0;
        if (gnt_o[1]) req_i[1] = 1'b0;
        ng++;
      end
      if (rvalid_o !== 2'b00) begin
        checks++;
        if (rvalid_o !== 2'b10 || rdata_o !== 4'b0101) begin
          errors++;
          $display("FAIL order_rdata: rvalid=%b rdata=%b, required 10 0101", rvalid_o, rdata_o);
        end
        got++;
      end
    end
    idle_inputs();
    checks++;
    if (got != 1 || ng != 2) begin
      errors++;
      $display("FAIL order_count: rvalids=%0d grants=%0d, required 1 2", got, ng);
    end
  endtask

  task automatic test_withdrawn;
    int got = 0;
    req_i = 2'b01; we_i = 2'b00; addr_i = {12'h002, 12'h001};
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL withdrawn_p0grant: gnt=%b, required 01", gnt_o);
    end
    req_i = 2'b10;
    tick();
    req_i = 2'b00;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (gnt_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL withdrawn_p1: gnt=%b, required port1 never granted", gnt_o);
      end
      if (rvalid_o !== 2'b00) begin
        checks++;
        if (rvalid_o !== 2'b01 || rdata_o !== 4'hA) begin
          errors++;
          $display("FAIL withdrawn_rdata: rvalid=%b rdata=%h, required 01 a", rvalid_o, rdata_o);
        end
        got++;
      end
    end
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL withdrawn_rvalid_count: %0d, required 1", got);
    end
    idle_inputs();
  endtask

  task automatic test_random;
    logic [DW-1:0] shadow [8];
    bit            pend [2];
    bit            pwe [2];
    logic [2:0]    pa [2];
    logic [DW-1:0] pd [2];
    int            qp [$];
    logic [DW-1:0] qd [$];
    int            issued = 0;
    int            grants = 0;
    for (int a = 0; a < 8; a++) begin
      shadow[a] = 4'($urandom);
      write_word(a % 2, 12'(a), shadow[a]);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    idle_inputs();
    for (int cyc = 0; cyc < 1100; cyc++) begin
      tick();
      if (gnt_o !== 2'b00) begin
        int p;
        p = gnt_o[1] ? 1 : 0;
        checks++;
        if (!pend[p]) begin
          errors++;
          $display("FAIL random_spurious_grant: gnt=%b, required no grant without request", gnt_o);
        end else begin
          grants++;
          if (pwe[p]) shadow[pa[p]] = pd[p];
          else begin
            qp.push_back(p);
            qd.push_back(shadow[pa[p]]);
          end
        end
        pend[p] = 1'b0; req_i[p] = 1'b0; we_i[p] = 1'b0;
      end
      if (rvalid_o !== 2'b00) begin
        checks++;
        if (qp.size() == 0) begin
          errors++;
          $display("FAIL random_spurious_rvalid: rvalid=%b, required no pending read", rvalid_o);
        end else begin
          int ep;
          logic [DW-1:0] ed;
          ep = qp.pop_front();
          ed = qd.pop_front();
          if (rvalid_o !== ((ep == 1) ? 2'b10 : 2'b01) || rdata_o !== ed) begin
            errors++;
            $display("FAIL random_read: rvalid=%b rdata=%h, required port%0d data %h", rvalid_o, rdata_o, ep, ed);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && cyc < 1000 && $urandom_range(2) == 0) begin
          pend[p] = 1'b1;
          pwe[p]  = 1'($urandom_range(1));
          pa[p]   = 3'($urandom_range(7));
          pd[p]   = 4'($urandom);
          req_i[p] = 1'b1; we_i[p] = pwe[p];
          addr_i[p*AW +: AW] = {9'b0, pa[p]};
          wdata_i[p*DW +: DW] = pd[p];
          issued++;
        end
      end
      if (cyc >= 1000 && !pend[0] && !pend[1] && qp.size() == 0) break;
    end
    idle_inputs();
    checks++;
    if (grants != issued || qp.size() != 0) begin
      errors++;
      $display("FAIL random_grant_count: grants=%0d outstanding_reads=%0d, required %0d 0",
               grants, qp.size(), issued);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_same_addr();
    test_withdrawn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
